debug_mem_dumper: RTL
=====================

# debug_mem_dumper

Debug-side initiator for the data-memory debug read port. On a start request it holds the pipeline in debug mode and walks data memory from word address 0 to DUMP_WORDS-1. For each word it presents the address, captures the synchronous BRAM read word, and streams the word as four bytes, MSB first, to the debug UART transmitter over a start/done byte handshake.

## Interface
Parameters:
- PROC_BITS, 32, data word width; fixed at 32, four bytes per word
- DATA_ADDRS_BITS, 10, data memory word-address width
- DUMP_WORDS, 128, number of words dumped; legal range 1 .. 2**DATA_ADDRS_BITS

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_mem_data  in  PROC_BITS  data-memory read word; valid one cycle after the address is presented
- i_tx_done  in  1  one-cycle pulse when the UART finishes the current byte
- o_debug_read_data  out  1  high while a dump is in progress; holds the pipeline and selects the debug address
- o_debug_read_address  out  DATA_ADDRS_BITS  word address presented to data memory
- o_tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_done
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the last byte of the last word

## Operation
- States: IDLE, ADDR, LATCH, SEND, WAIT_TX, DONE.
- IDLE: when i_start=1, clear the address to 0 and the byte index to 0, then go to ADDR.
- ADDR: drive the current address and wait one cycle for the BRAM read. Go to LATCH.
- LATCH: load i_mem_data into the 32-bit word register. Go to SEND.
- SEND: pulse o_tx_start. o_tx_data = word[31-8k : 24-8k] for byte index k. Go to WAIT_TX.
- WAIT_TX: hold until i_tx_done=1. On done:
  - k<3: k+1, go to SEND.
  - k=3 and address ≠ DUMP_WORDS-1: address+1, k=0, go to ADDR.
  - k=3 and address = DUMP_WORDS-1: go to DONE.
- DONE: pulse o_done for one cycle, go to IDLE.
- i_tx_done is ignored in every state except WAIT_TX.
- i_start is ignored in every state except IDLE, including DONE.
- The address counter is DATA_ADDRS_BITS wide and never wraps. With DUMP_WORDS = 2**DATA_ADDRS_BITS the last address is all-ones and the dump terminates there.
- o_debug_read_data = 1 in ADDR, LATCH, SEND and WAIT_TX. It is 0 in IDLE and DONE.
- o_debug_read_address is registered. It holds its value in IDLE and DONE (last address dumped) and is cleared only on start or reset.

## Timing
- Reset values: state IDLE; all outputs 0; address 0; word register 0; byte index 0.
- Reset is asynchronous. Asserting rst mid-dump returns the block to IDLE immediately. No further o_tx_start or o_done is issued, and a byte already handed to the UART is not retracted.
- Start latency: i_start high at cycle 0 (IDLE) gives o_debug_read_data=1 and address 0 from cycle 1.
- Per word:
  - ADDR 1 cycle, then LATCH 1 cycle.
  - First o_tx_start in cycle 3 relative to ADDR entry at cycle 1 (ADDR=1, LATCH=2, SEND=3).
  - Each byte takes 1 SEND cycle plus the WAIT_TX cycles up to and including the i_tx_done cycle.
- With i_tx_done arriving at the earliest point (first WAIT_TX cycle), one word takes 2+4×2 = 10 cycles.
- o_done rises in the cycle after the final i_tx_done. o_busy falls one cycle later.

## Structure
- State encoding (3-bit localparams) and BYTE_BITS=8 go in the shared constants header alongside PROC_BITS and DATA_ADDRS_BITS.
- Optional sub-module dump_word_serializer: word register, 2-bit byte index and MSB-first byte select. The top level keeps the FSM and the address counter.

## Test plan
- Reset: assert rst mid-SEND -> all outputs 0 immediately; no o_tx_start after release until a new i_start.
- DUMP_WORDS=2, mem[0]=0x11223344, mem[1]=0xA5B6C7D8, tx_done 1 cycle after each start -> bytes 11,22,33,44,A5,B6,C7,D8 in order; o_done one cycle after the 8th done.
- Variable UART latency (tx_done 0..20 random cycles after start) -> o_tx_data stable until each done; exactly one o_tx_start per byte.
- i_start pulsed during WAIT_TX and in the DONE cycle -> ignored; the dump completes once.
- Spurious i_tx_done in ADDR/LATCH/SEND -> no byte skipped; the sequence is unchanged.
- DATA_ADDRS_BITS=3, DUMP_WORDS=8 -> addresses 0..7 in order; terminates at 7 without wrapping to 0; 32 bytes total.

Source files
------------

// File: rtl/debug_mem_dumper_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the data-memory dumper.
package debug_mem_dumper_pkg;

  localparam int unsigned PROC_BITS       = 32;
  localparam int unsigned DATA_ADDRS_BITS = 10;
  localparam int unsigned BYTE_BITS       = 8;

  // 3-bit state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StAddr   = ST_ADDR,
    StLatch  = ST_LATCH,
    StSend   = ST_SEND,
    StWaitTx = ST_WAIT_TX,
    StDone   = ST_DONE
  } state_e;

  // Byte idx of a word counted from the most significant end (idx 0 = bits 31:24).
  function automatic logic [BYTE_BITS-1:0] msb_first_byte(input logic [PROC_BITS-1:0] word,
                                                          input logic [1:0]           idx);
    logic [PROC_BITS-1:0] shifted;
    shifted = word << {idx, 3'b000};
    return shifted[PROC_BITS-1 -: BYTE_BITS];
  endfunction

endpackage

// File: rtl/debug_mem_dumper_serializer.sv
// Holds the captured memory word and hands it out one byte at a time, MSB first.
module debug_mem_dumper_serializer (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      load,
  input  logic [debug_mem_dumper_pkg::PROC_BITS-1:0] word_in,
  input  logic                                      clear_idx,
  input  logic                                      advance,
  output logic [debug_mem_dumper_pkg::BYTE_BITS-1:0] tx_byte,
  output logic [1:0]                                byte_idx,
  output logic                                      last_byte
);
  import debug_mem_dumper_pkg::*;

  logic [PROC_BITS-1:0] word_q;
  logic [1:0]           idx_q;

  // Word register: captured from the BRAM read port once per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= word_in;
    end
  end

  // Byte index: wraps 3 -> 0 naturally at the end of each word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 2'd0;
    end else if (clear_idx) begin
      idx_q <= 2'd0;
    end else if (advance) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Byte select is combinational so tx_byte stays put while the index holds.
  always_comb begin
    tx_byte   = msb_first_byte(word_q, idx_q);
    byte_idx  = idx_q;
    last_byte = (idx_q == 2'd3);
  end

endmodule

// File: rtl/debug_mem_dumper.sv
// Walks data memory from word 0 to DUMP_WORDS-1 through the debug read port and streams
// every word to the debug UART as four bytes, MSB first.
module debug_mem_dumper #(
  parameter int unsigned PROC_BITS       = debug_mem_dumper_pkg::PROC_BITS,
  parameter int unsigned DATA_ADDRS_BITS = debug_mem_dumper_pkg::DATA_ADDRS_BITS,
  parameter int unsigned DUMP_WORDS      = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [PROC_BITS-1:0]       i_mem_data,
  input  logic                       i_tx_done,
  output logic                       o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0] o_debug_read_address,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_start,
  output logic                       o_busy,
  output logic                       o_done
);
  import debug_mem_dumper_pkg::*;

  // Counter stops here; with a full-memory dump this is all-ones and never wraps.
  localparam logic [DATA_ADDRS_BITS-1:0] LastAddr = DATA_ADDRS_BITS'(DUMP_WORDS - 1);

  state_e                     state_q, state_d;
  logic [DATA_ADDRS_BITS-1:0] addr_q, addr_d;

  logic                       load_word;
  logic                       clear_idx;
  logic                       advance_idx;
  logic [BYTE_BITS-1:0]       tx_byte;
  logic [1:0]                 byte_idx;
  logic                       last_byte;

  debug_mem_dumper_serializer u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (load_word),
    .word_in   (i_mem_data),
    .clear_idx (clear_idx),
    .advance   (advance_idx),
    .tx_byte   (tx_byte),
    .byte_idx  (byte_idx),
    .last_byte (last_byte)
  );

  // State and address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; i_start only matters in idle, i_tx_done only while waiting on the UART.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    load_word   = 1'b0;
    clear_idx   = 1'b0;
    advance_idx = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          addr_d    = '0;
          clear_idx = 1'b1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        state_d = StLatch;
      end
      StLatch: begin
        load_word = 1'b1;
        state_d   = StSend;
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (i_tx_done) begin
          advance_idx = 1'b1;
          if (!last_byte) begin
            state_d = StSend;
          end else if (addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + DATA_ADDRS_BITS'(1);
            state_d = StAddr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from the state so an async reset clears them at once.
  always_comb begin
    o_debug_read_data    = (state_q == StAddr) || (state_q == StLatch) ||
                           (state_q == StSend) || (state_q == StWaitTx);
    o_debug_read_address = addr_q;
    o_tx_data            = tx_byte;
    o_tx_start           = (state_q == StSend);
    o_busy               = (state_q != StIdle);
    o_done               = (state_q == StDone);
  end

  logic unused_byte_idx;
  assign unused_byte_idx = ^byte_idx;

endmodule
